// File: rtl/aes_spi_sequencer.sv
// aes_spi_sequencer: sends one AES frame (hdr, data, key size, key) over the SPI master and reads back the result.
// Optional: define SEQ_TIMEOUT_EN to add a watchdog on every m_done / s_ready wait.
module aes_spi_sequencer #(
  parameter int DATA_BYTES = 16,
  parameter int MAX_KEY_BYTES = 32,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       req,
  input  logic                       mode,
  input  logic [1:0]                 key_size,
  input  logic [8*DATA_BYTES-1:0]    data_in,
  input  logic [8*MAX_KEY_BYTES-1:0] key_in,
  output logic                       busy,
  output logic                       done,
  output logic                       error,
  output logic [8*DATA_BYTES-1:0]    result,
  output logic                       m_start,
  output logic [7:0]                 m_data_in,
  input  logic [7:0]                 m_data_out,
  input  logic                       m_done,
  input  logic                       m_busy,
  input  logic                       s_ready
);
  localparam int CW = $clog2(DATA_BYTES + MAX_KEY_BYTES + 2);
  localparam int DW = 8 * DATA_BYTES;
  localparam int KW = 8 * MAX_KEY_BYTES;
  typedef enum logic [2:0] {IDLE, HDR, DATA, KSZ, KEY, WAIT, RECV} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0] nkey_q, nkey_d, ksz;
  logic mode_q, mode_d, pend_q, pend_d, done_q, done_d, error_q, error_d;
  logic [DW-1:0] data_q, data_d, shadow_q, shadow_d, result_q, result_d;
  logic [KW-1:0] key_q, key_d;
  logic tx, fire, last, timeout;
  // pend_q marks a byte handed to the master whose m_done has not arrived yet
  assign tx = state_q inside {HDR, DATA, KSZ, KEY, RECV};
  assign fire = pend_q && m_done;
  assign ksz = 8'd16 + {3'b0, key_size, 3'b0};
  assign last = (state_q == KEY) ? (int'(cnt_q) == int'(nkey_q) - 1) : (int'(cnt_q) == DATA_BYTES - 1);
  assign m_start = tx && !pend_q && !m_busy;
  assign m_data_in = (state_q == HDR)  ? {mode_q, 7'b0} :
                     (state_q == DATA) ? data_q[DW-1 -: 8] :
                     (state_q == KSZ)  ? nkey_q :
                     (state_q == KEY)  ? key_q[KW-1 -: 8] : 8'h00;
  assign busy = state_q != IDLE;
  assign done = done_q;
  assign error = error_q;
  assign result = result_q;
`ifdef SEQ_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
  logic [WW-1:0] wd_q, wd_d;
  logic waiting;
  assign waiting = (pend_q && !m_done) || (state_q == WAIT && !s_ready);
  assign wd_d = waiting ? wd_q + 1'b1 : '0;
  assign timeout = waiting && (int'(wd_q) == TIMEOUT_CYCLES - 1);
  always_ff @(posedge clk) wd_q <= reset ? '0 : wd_d;
`else
  assign timeout = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    cnt_d = fire ? cnt_q + 1'b1 : cnt_q;
    nkey_d = nkey_q;
    mode_d = mode_q;
    data_d = data_q;
    key_d = key_q;
    shadow_d = shadow_q;
    result_d = result_q;
    pend_d = m_start || (pend_q && !m_done);
    done_d = 1'b0;
    error_d = 1'b0;
    case (state_q)
      IDLE: if (req && key_size == 2'b11) error_d = 1'b1;
        else if (req) begin
          state_d = HDR;
          cnt_d = '0;
          mode_d = mode;
          data_d = data_in;
          nkey_d = ksz;
          key_d = key_in << (KW - 8 * int'(ksz));
        end
      HDR: if (fire) begin
          state_d = DATA;
          cnt_d = '0;
        end
      DATA: if (fire) begin
          data_d = data_q << 8;
          if (last) begin
            state_d = KSZ;
            cnt_d = '0;
          end
        end
      KSZ: if (fire) begin
          state_d = KEY;
          cnt_d = '0;
        end
      KEY: if (fire) begin
          key_d = key_q << 8;
          if (last) begin
            state_d = WAIT;
            cnt_d = '0;
          end
        end
      WAIT: if (s_ready) begin
          state_d = RECV;
          cnt_d = '0;
        end
      RECV: if (fire) begin
          shadow_d[8*(DATA_BYTES-1-int'(cnt_q)) +: 8] = m_data_out;
          if (last) begin
            state_d = IDLE;
            cnt_d = '0;
            result_d = shadow_d;
            done_d = 1'b1;
          end
        end
      default: state_d = IDLE;
    endcase
    if (timeout) begin
      state_d = IDLE;
      cnt_d = '0;
      pend_d = 1'b0;
      error_d = 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      nkey_q <= '0;
      mode_q <= 1'b0;
      data_q <= '0;
      key_q <= '0;
      shadow_q <= '0;
      result_q <= '0;
      pend_q <= 1'b0;
      done_q <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      nkey_q <= nkey_d;
      mode_q <= mode_d;
      data_q <= data_d;
      key_q <= key_d;
      shadow_q <= shadow_d;
      result_q <= result_d;
      pend_q <= pend_d;
      done_q <= done_d;
      error_q <= error_d;
    end
  end
endmodule

// File: tb/tb_aes_spi_sequencer.sv
// tb_aes_spi_sequencer: drives aes_spi_sequencer against an SPI master/slave model and checks frames and results.
module tb_aes_spi_sequencer;
  logic clk = 1'b0;
  logic reset, req, mode, s_ready, m_done_x;
  logic m_busy = 1'b0, m_done_m = 1'b0;
  logic m_done, busy, done, error, m_start;
  logic [1:0] key_size;
  logic [127:0] data_in, result, prev, vd, r256, r128, r192, rd, rr;
  logic [255:0] key_in, k256, k128, k192, rk;
  logic [7:0] m_data_in, held;
  logic [7:0] m_data_out = 8'h00;
  logic [7:0] txq[$];
  logic [7:0] reply[16];
  logic [4:0] rx_idx = '0;
  int asserts = 0, fails = 0, viol = 0, lat = 0, tail = 0, base = 0, cnt = 0, cyc = 0;
  always #5 clk = ~clk;
  assign m_done = m_done_m | m_done_x;
  aes_spi_sequencer #(.TIMEOUT_CYCLES(64)) dut (
    .clk(clk), .reset(reset), .req(req), .mode(mode), .key_size(key_size),
    .data_in(data_in), .key_in(key_in), .busy(busy), .done(done), .error(error),
    .result(result), .m_start(m_start), .m_data_in(m_data_in), .m_data_out(m_data_out),
    .m_done(m_done), .m_busy(m_busy), .s_ready(s_ready)
  );
  // SPI master + slave: logs every started byte, answers with reply[] once s_ready is up
  always @(posedge clk) begin
    m_done_m <= 1'b0;
    if (!s_ready) rx_idx <= '0;
    if (reset) begin
      m_busy <= 1'b0;
      lat <= 0;
      tail <= 0;
    end else if (m_start) begin
      if (m_busy || lat != 0) viol <= viol + 1;
      txq.push_back(m_data_in);
      held <= m_data_in;
      m_busy <= 1'b1;
      lat <= $urandom_range(1, 4);
    end else if (lat != 0) begin
      if (m_data_in !== held) viol <= viol + 1;
      lat <= lat - 1;
      if (lat == 1) begin
        m_done_m <= 1'b1;
        m_data_out <= s_ready ? reply[rx_idx[3:0]] : 8'($urandom);
        if (s_ready) rx_idx <= rx_idx + 1'b1;
        tail <= $urandom_range(0, 2);
      end
    end else if (tail != 0) tail <= tail - 1;
    else m_busy <= 1'b0;
  end
  task automatic check(input logic [255:0] obs, input logic [255:0] exp, input string tag);
    asserts++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic run_txn(input logic md, input logic [1:0] ks, input logic [127:0] d, input logic [255:0] k,
                         input logic [127:0] rep, input bit hold, input string tag);
    logic [7:0] exp[$];
    int n, b0, c, bad;
    n = 16 + 8 * int'(ks);
    exp.push_back({md, 7'b0});
    for (int i = 0; i < 16; i++) exp.push_back(d[127-8*i -: 8]);
    exp.push_back(8'(n));
    for (int i = n - 1; i >= 0; i--) exp.push_back(k[8*i +: 8]);
    for (int i = 0; i < 16; i++) exp.push_back(8'h00);
    for (int i = 0; i < 16; i++) reply[i] = rep[127-8*i -: 8];
    b0 = txq.size();
    mode = md; key_size = ks; data_in = d; key_in = k; req = 1'b1;
    @(negedge clk);
    req = hold;
    mode = ~md; key_size = 2'($urandom_range(0, 2)); data_in = ~d;
    key_in = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    for (c = 0; c < 3000 && txq.size() < b0 + n + 18; c++) @(negedge clk);
    check(txq.size() - b0, n + 18, {tag, "_txcount"});
    repeat (8 + $urandom_range(0, 4)) @(negedge clk);
    check(busy, 1, {tag, "_wait_busy"});
    m_done_x = 1'b1;
    @(negedge clk);
    m_done_x = 1'b0;
    s_ready = 1'b1;
    for (c = 0; c < 3000 && !done; c++) @(negedge clk);
    check(done, 1, {tag, "_done"});
    check(busy, 0, {tag, "_busy_at_done"});
    check(result, rep, {tag, "_result"});
    bad = 0;
    for (int i = 0; i < exp.size(); i++) if (b0 + i >= txq.size() || txq[b0+i] !== exp[i]) bad++;
    check(bad, 0, {tag, "_frame_bytes_wrong"});
    check(txq.size() - b0, exp.size(), {tag, "_total_starts"});
    check(viol, 0, {tag, "_handshake_violations"});
    s_ready = 1'b0;
    @(negedge clk);
    check(done, 0, {tag, "_done_width"});
    check(busy, hold, {tag, "_restart"});
  endtask
  initial begin
    reset = 1'b1; req = 1'b0; mode = 1'b0; key_size = 2'b00; data_in = '0; key_in = '0;
    s_ready = 1'b0; m_done_x = 1'b0;
    vd = 128'h00112233445566778899aabbccddeeff;
    r256 = 128'h8ea2b7ca516745bfeafc49904b496089;
    r128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    r192 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    k256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    k128 = {128'hdeadbeef0badf00dcafef00d12345678, 128'h000102030405060708090a0b0c0d0e0f};
    k192 = {64'hfeedfacecafebeef, 192'h000102030405060708090a0b0c0d0e0f1011121314151617};
    repeat (3) @(negedge clk);
    check(busy, 0, "rst_busy");
    check(done, 0, "rst_done");
    check(error, 0, "rst_error");
    check(m_start, 0, "rst_m_start");
    check(m_data_in, 0, "rst_m_data_in");
    check(result, 0, "rst_result");
    reset = 1'b0;
    @(negedge clk);
    run_txn(1'b0, 2'd2, vd, k256, r256, 1'b0, "aes256_enc");
    run_txn(1'b0, 2'd0, vd, k128, r128, 1'b0, "aes128_enc");
    run_txn(1'b0, 2'd1, vd, k192, r192, 1'b0, "aes192_enc");
    run_txn(1'b1, 2'd2, r256, k256, vd, 1'b1, "aes256_dec");
    req = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check(result, 0, "abort_result_cleared");
    base = txq.size();
    key_size = 2'b11; req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    check(error, 1, "badkey_error");
    check(busy, 0, "badkey_busy");
    @(negedge clk);
    check(error, 0, "badkey_error_width");
    repeat (5) @(negedge clk);
    check(txq.size() - base, 0, "badkey_no_m_start");
    check(result, 0, "badkey_result_held");
    base = txq.size();
    mode = 1'b0; key_size = 2'd2; data_in = vd; key_in = k256; req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    for (int c = 0; c < 500 && txq.size() < base + 10; c++) @(negedge clk);
    check(txq.size() - base, 10, "midrst_reached_10");
    reset = 1'b1;
    @(negedge clk);
    check(busy, 0, "midrst_busy");
    check(m_start, 0, "midrst_m_start");
    check(done, 0, "midrst_done");
    reset = 1'b0;
    cnt = 0;
    repeat (20) begin
      @(negedge clk);
      if (done || busy || error) cnt++;
    end
    check(cnt, 0, "midrst_quiet");
    run_txn(1'b0, 2'd0, vd, k128, r128, 1'b0, "post_rst");
    for (int t = 0; t < 5; t++) begin
      rd = {$urandom, $urandom, $urandom, $urandom};
      rr = {$urandom, $urandom, $urandom, $urandom};
      rk = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      run_txn(1'($urandom), 2'($urandom_range(0, 2)), rd, rk, rr, 1'b0, $sformatf("rnd%0d", t));
    end
`ifdef SEQ_TIMEOUT_EN
    prev = result;
    base = txq.size();
    mode = 1'b0; key_size = 2'd0; data_in = vd; key_in = k128; req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    for (int c = 0; c < 3000 && txq.size() < base + 34; c++) @(negedge clk);
    for (cyc = 0; cyc < 200 && !error; cyc++) @(negedge clk);
    check(error, 1, "timeout_error");
    check(cyc >= 55 && cyc <= 70, 1, "timeout_delay_window");
    check(busy, 0, "timeout_idle");
    check(done, 0, "timeout_no_done");
    check(result, prev, "timeout_result_held");
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end
endmodule

// File: doc/aes_spi_sequencer.md
Name: aes_spi_sequencer

Overview:
Synthesizable host-side sequencer that runs one complete AES transaction over the existing SPI master byte interface. It sends a header, the data block, the key-size byte and the key, waits for the slave's result-ready flag, then reads back the result block. It replaces the hand-coded bench sequencing and adds encrypt/decrypt mode, runtime key size selection and error reporting. It sits between a user request interface and the SPI master.

Parameters:
DATA_BYTES, 16, bytes in the data/result block
MAX_KEY_BYTES, 32, width of key_in in bytes
TIMEOUT_CYCLES, 4096, watchdog limit per wait (used only with SEQ_TIMEOUT_EN)

Ports:
clk  in  1  clock
reset  in  1  reset, synchronous, active-high
req  in  1  start a transaction; sampled only in IDLE
mode  in  1  0=encrypt, 1=decrypt
key_size  in  2  00=128, 01=192, 10=256, 11=invalid
data_in  in  8*DATA_BYTES  block to process, MSB byte sent first
key_in  in  8*MAX_KEY_BYTES  key, right-aligned; the low N bytes are used, MSB first
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse when result is valid
error  out  1  one-cycle pulse on invalid key_size or timeout
result  out  8*DATA_BYTES  received block, held until next done
m_start  out  1  one-cycle byte-transfer request to SPI master
m_data_in  out  8  byte to transmit
m_data_out  in  8  byte received by master
m_done  in  1  master byte-complete pulse
m_busy  in  1  master busy
s_ready  in  1  slave result available

Behaviour:
- Reset: state IDLE; busy, done, error, m_start = 0; m_data_in = 0; result = 0; all counters = 0. Reset mid-transaction aborts immediately; no done or error pulse is issued.
- Acceptance: when IDLE and req=1, latch mode, key_size, data_in and key_in. Changes to these inputs afterwards are ignored.
- If key_size=11 on acceptance: error pulses the next cycle; state stays IDLE; m_start is never asserted.
- Key bytes N = 16/24/32. Key-size byte value = N (8'h10/8'h18/8'h20).
- Frame order: HDR byte {mode,7'b0}, then DATA_BYTES data bytes, then KSZ byte, then N key bytes. Total transmitted = DATA_BYTES + N + 2.
- States: IDLE -> HDR -> DATA -> KSZ -> KEY -> WAIT -> RECV -> IDLE.
- Per-byte handshake (every transmit state):
  - Drive m_data_in and pulse m_start for exactly one cycle, only when m_busy=0.
  - Hold m_data_in stable until m_done.
  - On m_done, advance the byte counter. The next m_start is issued no earlier than the cycle after m_done.
  - An m_done received while no byte is outstanding is ignored.
- WAIT: remain until s_ready=1, then enter RECV.
- RECV: issue DATA_BYTES transfers with m_data_in=8'h00. Each byte is captured on m_done, MSB byte first, into a shadow register.
- Completion: on the final m_done, copy the shadow register to result and pulse done in the following cycle. busy falls in the same cycle as done.
- req held high across done starts a new transaction only after one IDLE cycle.
- Counter width is clog2(DATA_BYTES+MAX_KEY_BYTES+2). No wrap-around: counters reset on every state entry.

Optional Feature:
SEQ_TIMEOUT_EN
- Defined: a watchdog counts cycles while waiting for m_done or s_ready and is cleared on every event.
  - On reaching TIMEOUT_CYCLES: pulse error, deassert m_start, return to IDLE.
  - result is left unchanged and done is not pulsed.
- Undefined: no watchdog logic. The block waits indefinitely, and TIMEOUT_CYCLES has no effect.

Test Plan:
- AES-256 encrypt, data=00112233445566778899aabbccddeeff, key=000102..1f -> 50 bytes sent (HDR 8'h00, KSZ 8'h20); done with result=8ea2b7ca516745bfeafc49904b496089.
- AES-128 encrypt, same data, key=000102..0f -> 34 bytes sent, KSZ 8'h10, result=69c4e0d86a7b0430d8cdb78070b4c55a. AES-192 with key 00..17 -> result=dda97ca4864cdfe06eaf70a0ec0d7191.
- Decrypt (mode=1), data=8ea2b7ca516745bfeafc49904b496089, 256-bit key -> HDR 8'h80, result=00112233445566778899aabbccddeeff.
- key_size=11 with req=1 -> error pulses for 1 cycle, busy stays 0, zero m_start pulses.
- Reset asserted after the 10th byte -> next cycle busy=0 and m_start=0, no done; a new req then completes normally.
- With SEQ_TIMEOUT_EN and TIMEOUT_CYCLES=64, s_ready held 0 -> error pulses 64 cycles after the last key byte, state returns to IDLE, result unchanged.
